// File: rtl/lc_ctrl_pwr_seq_if.sv
// lc_ctrl power/clock-bypass handshake bundle.
//   lc_init     : sequencer -> lc_ctrl, pwr_lc_req.lc_init
//   lc_done     : lc_ctrl -> sequencer, pwr_lc_rsp.lc_done
//   lc_idle     : lc_ctrl -> sequencer, pwr_lc_rsp.lc_idle
//   clk_byp_req : lc_ctrl -> sequencer, lc_tx_t clock-bypass request
//   clk_byp_ack : sequencer -> lc_ctrl, lc_tx_t clock-bypass acknowledge
// master = sequencer side, slave = lc_ctrl side.
interface lc_ctrl_pwr_seq_if;
    logic       lc_init;
    logic       lc_done;
    logic       lc_idle;
    logic [3:0] clk_byp_req;
    logic [3:0] clk_byp_ack;

    modport master (
        output lc_init,
        output clk_byp_ack,
        input  lc_done,
        input  lc_idle,
        input  clk_byp_req
    );

    modport slave (
        input  lc_init,
        input  clk_byp_ack,
        output lc_done,
        output lc_idle,
        output clk_byp_req
    );
endinterface

// File: rtl/lc_ctrl_pwr_seq.sv
// lc_ctrl power-up sequencer and clock-bypass responder.
//   Waits INIT_DELAY cycles after cptra_pwrgood, raises lc_init until lc_done (or a
//   DONE_TIMEOUT expiry), and acks lc_clk_byp_req after BYP_ACK_DELAY cycles of On.
// Ports:
//   clk, reset_n    : clock, asynchronous active-low reset
//   cptra_pwrgood   : power good; low returns the sequencer to idle
//   restart_i       : re-run the init sequence from DONE or ERR
//   lc_if           : lc_ctrl handshake bundle (master side)
//   init_busy_o     : sequencer is delaying or requesting
//   init_done_o     : lc_done received
//   init_err_o      : lc_done timed out (sticky)
//   lc_ready_o      : init_done_o & lc_idle
module lc_ctrl_pwr_seq #(
    parameter int unsigned INIT_DELAY    = 500,
    parameter int unsigned DONE_TIMEOUT  = 4096,
    parameter int unsigned BYP_ACK_DELAY = 4,
    parameter int unsigned CNT_W         = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   cptra_pwrgood,
    input  logic                   restart_i,
    lc_ctrl_pwr_seq_if.master      lc_if,
    output logic                   init_busy_o,
    output logic                   init_done_o,
    output logic                   init_err_o,
    output logic                   lc_ready_o
);
    localparam logic [3:0]       LcTxOn    = 4'b0101;
    localparam logic [3:0]       LcTxOff   = 4'b1010;
    localparam logic [CNT_W-1:0] InitLast  = CNT_W'(INIT_DELAY - 1);
    localparam logic [CNT_W-1:0] ToLast    = CNT_W'(DONE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] BypDelay  = CNT_W'(BYP_ACK_DELAY);
    localparam logic [CNT_W-1:0] CntMax    = '1;
    localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

    typedef enum logic [2:0] {StIdle, StDelay, StReq, StDone, StErr} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [CNT_W-1:0] byp_cnt_q, byp_cnt_d;
    logic             lc_init_q, lc_init_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [3:0]       ack_q, ack_d;
    logic             req_on;

    // Sequencer next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;
        if (!cptra_pwrgood) begin
            // Power loss overrides restart and lc_done
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StDelay;
                    cnt_d   = '0;
                end
                StDelay: begin
                    if (cnt_q == InitLast) begin
                        state_d = StReq;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                StReq: begin
                    // lc_done wins over a coincident timeout
                    if (lc_if.lc_done) begin
                        state_d = StDone;
                        cnt_d   = '0;
                    end else if (cnt_q == ToLast) begin
                        state_d = StErr;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                StDone, StErr: begin
                    if (restart_i) begin
                        state_d = StDelay;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end

        // Outputs are registered copies of the next-state decode
        lc_init_d = (state_d == StReq);
        busy_d    = (state_d == StDelay) || (state_d == StReq);
        done_d    = (state_d == StDone);
        err_d     = (state_d == StErr);
    end

    // Clock bypass: count consecutive On samples; anything else drops the ack
    always_comb begin
        req_on    = (lc_if.clk_byp_req == LcTxOn);
        byp_cnt_d = '0;
        ack_d     = LcTxOff;
        if (req_on) begin
            byp_cnt_d = (byp_cnt_q == CntMax) ? byp_cnt_q : byp_cnt_q + CntOne;
            if (byp_cnt_d >= BypDelay) begin
                ack_d = LcTxOn;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            byp_cnt_q <= '0;
            lc_init_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            ack_q     <= LcTxOff;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            byp_cnt_q <= byp_cnt_d;
            lc_init_q <= lc_init_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            ack_q     <= ack_d;
        end
    end

    assign lc_if.lc_init     = lc_init_q;
    assign lc_if.clk_byp_ack = ack_q;
    assign init_busy_o       = busy_q;
    assign init_done_o       = done_q;
    assign init_err_o        = err_q;
    assign lc_ready_o        = done_q & lc_if.lc_idle;
endmodule
